// File: rtl/mips_alu_pkg.sv
// ---------------------------------------------------------------------------
// mips_alu_pkg
//   Shared definitions for the ALU shift path.
//   - State encoding of the serial shifter control FSM.
//   - Default data / shift-amount widths.
//   - Step select for the shr_step datapath slice.
//   - MIPS R-type function codes for the right shifts, plus helpers used by
//     the decoder that derives the 'arith' control bit.
// ---------------------------------------------------------------------------
package mips_alu_pkg;

    // Default widths; 2**DEF_SHAMT_W must equal DEF_WIDTH.
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    // Control FSM states of serial_shift_right.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shr_state_e;

    // How far shr_step moves the register in one cycle.
    typedef enum logic {
        STEP_1 = 1'b0,
        STEP_4 = 1'b1
    } shr_step_e;

    // R-type function codes of the right shifts.
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;

    // True for any of the four right-shift function codes.
    function automatic logic is_shr_funct(input logic [5:0] funct);
        return (funct == FUNCT_SRL)  || (funct == FUNCT_SRA) ||
               (funct == FUNCT_SRLV) || (funct == FUNCT_SRAV);
    endfunction

    // True when the function code asks for sign fill (SRA / SRAV).
    function automatic logic is_arith_funct(input logic [5:0] funct);
        return (funct == FUNCT_SRA) || (funct == FUNCT_SRAV);
    endfunction

endpackage

// File: rtl/serial_shift_right_shr_step.sv
// ---------------------------------------------------------------------------
// shr_step
//   Combinational one-step right shift of the working register.
//   Ports:
//     reg_i   [WIDTH-1:0]  current working register
//     fill_i               bit shifted in at the top (sign or zero)
//     step_i               STEP_1: shift by 1, STEP_4: shift by 4
//     reg_o   [WIDTH-1:0]  working register after this step
// ---------------------------------------------------------------------------
module shr_step
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] reg_i,
    input  logic             fill_i,
    input  shr_step_e        step_i,
    output logic [WIDTH-1:0] reg_o
);

    always_comb begin
        reg_o = {fill_i, reg_i[WIDTH-1:1]};
        if (step_i == STEP_4) begin
            reg_o = {{4{fill_i}}, reg_i[WIDTH-1:4]};
        end
    end

endmodule

// File: rtl/serial_shift_right.sv
// ---------------------------------------------------------------------------
// serial_shift_right
//   Multi-cycle logical / arithmetic right shift (SRL/SRA/SRLV/SRAV) for the
//   ALU path. Shifts one bit per cycle; the pipeline stalls while busy=1.
//
//   Ports:
//     clk                  clock, rising edge
//     rst_n                asynchronous active-low reset
//     start                request, sampled only while busy=0
//     data_in [WIDTH-1:0]  operand (rt value)
//     shamt   [SHAMT_W-1:0] shift amount 0..WIDTH-1
//     arith                1 = sign fill (SRA/SRAV), 0 = zero fill
//     busy                 high from the cycle after accept through DONE
//     done                 one-cycle pulse, result valid in that cycle
//     result  [WIDTH-1:0]  shifted value, held until the next accept
//     dbg_state [1:0]      current FSM state (debug observation only)
//
//   Handshake: a request is accepted on a rising edge where start=1 and the
//   FSM is IDLE (busy=0). Operands are captured only at that edge; start or
//   operand changes while busy are ignored, not queued. done pulses for one
//   cycle (shamt+2 cycles after the accept cycle in the default build); the
//   DONE cycle itself never accepts, so the next accept is the following
//   IDLE cycle.
//
//   Configuration macro SERIAL_SHIFT_RIGHT_FAST4_EN: when defined, the SHIFT
//   state moves 4 bits per cycle while at least 4 remain, giving latency
//   floor(shamt/4) + (shamt mod 4) + 2 with identical results.
//
//   SHAMT_W must satisfy 2**SHAMT_W == WIDTH (and SHAMT_W >= 3).
// ---------------------------------------------------------------------------
module serial_shift_right
    import mips_alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [1:0]         dbg_state
);

    shr_state_e         state_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   sreg_q;
    logic [SHAMT_W-1:0] count_q;
    logic               fill_q;

    shr_step_e          step_sel;
    logic [WIDTH-1:0]   sreg_d;
    logic [SHAMT_W-1:0] count_d;

    // Step size for the current SHIFT cycle.
`ifdef SERIAL_SHIFT_RIGHT_FAST4_EN
    always_comb begin
        step_sel = STEP_1;
        if (count_q >= SHAMT_W'(4)) begin
            step_sel = STEP_4;
        end
    end
`else
    assign step_sel = STEP_1;
`endif

    always_comb begin
        count_d = count_q - SHAMT_W'(1);
        if (step_sel == STEP_4) begin
            count_d = count_q - SHAMT_W'(4);
        end
    end

    shr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .reg_i  (sreg_q),
        .fill_i (fill_q),
        .step_i (step_sel),
        .reg_o  (sreg_d)
    );

    // Control FSM. busy/done are registered alongside the state so they
    // carry no combinational path from start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            sreg_q   <= '0;
            count_q  <= '0;
            fill_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sreg_q  <= data_in;
                        count_q <= shamt;
                        // Sign fill is frozen here, so a positive operand
                        // with arith=1 shifts in zeros.
                        fill_q  <= arith & data_in[WIDTH-1];
                        state_q <= S_SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (count_q != '0) begin
                        sreg_q  <= sreg_d;
                        count_q <= count_d;
                    end else begin
                        result_q <= sreg_q;
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_shift_right.sv
// ---------------------------------------------------------------------------
// tb_serial_shift_right
//   Directed table of operands with hand-computed results and latencies,
//   hand-written handshake / abort sequences, and a reference-operator
//   sweep. Honours SERIAL_SHIFT_RIGHT_FAST4_EN for expected latencies.
// ---------------------------------------------------------------------------
module tb_serial_shift_right;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    serial_shift_right #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .shamt     (shamt),
        .arith     (arith),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] exp;
        logic [7:0]  lat_base;
        logic [7:0]  lat_fast;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called in the cycle after the accept edge; returns in the done cycle.
    task automatic wait_done(output int lat, output logic [31:0] res, output bit busy_ok);
        lat = -1;
        res = '0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                res = result;
                return;
            end
            tick();
        end
    endtask

    // Must be called from an IDLE cycle.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                          output int lat, output logic [31:0] res, output bit busy_ok);
        data_in = d;
        shamt   = s;
        arith   = a;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        wait_done(lat, res, busy_ok);
    endtask

    function automatic int model_lat(input logic [4:0] s);
`ifdef SERIAL_SHIFT_RIGHT_FAST4_EN
        return int'(s) / 4 + int'(s) % 4 + 2;
`else
        return int'(s) + 2;
`endif
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          lat;
        logic [31:0] res;
        bit          busy_ok;
        logic [31:0] exp_lat;
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic signed [31:0] sd;
        logic [31:0] exp;
        bit          done_seen;

        vecs[0]  = '{32'h8000_00F0, 5'd4,  1'b0, 32'h0800_000F, 8'd6,  8'd3};
        vecs[1]  = '{32'hF000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 8'd33, 8'd12};
        vecs[2]  = '{32'hF000_0000, 5'd31, 1'b0, 32'h0000_0001, 8'd33, 8'd12};
        vecs[3]  = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 8'd2,  8'd2};
        vecs[4]  = '{32'h8000_0000, 5'd9,  1'b1, 32'hFFC0_0000, 8'd11, 8'd5};
        vecs[5]  = '{32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 8'd33, 8'd12};
        vecs[6]  = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 8'd33, 8'd12};
        vecs[7]  = '{32'h8000_0000, 5'd1,  1'b1, 32'hC000_0000, 8'd3,  8'd3};
        vecs[8]  = '{32'h8765_4321, 5'd8,  1'b0, 32'h0087_6543, 8'd10, 8'd4};
        vecs[9]  = '{32'h8765_4321, 5'd8,  1'b1, 32'hFF87_6543, 8'd10, 8'd4};
        vecs[10] = '{32'hDEAD_BEEF, 5'd16, 1'b0, 32'h0000_DEAD, 8'd18, 8'd6};
        vecs[11] = '{32'hDEAD_BEEF, 5'd3,  1'b1, 32'hFBD5_B7DD, 8'd5,  8'd5};
        vecs[12] = '{32'h0000_0001, 5'd5,  1'b1, 32'h0000_0000, 8'd7,  8'd4};
        vecs[13] = '{32'h4000_0000, 5'd30, 1'b1, 32'h0000_0001, 8'd32, 8'd11};

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        arith   = 1'b0;
        repeat (3) tick();

        // Reset state
        check("reset_busy",   {31'd0, busy},   32'd0);
        check("reset_done",   {31'd0, done},   32'd0);
        check("reset_result", result,          32'd0);
        check("reset_state",  {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].d, vecs[i].s, vecs[i].a, lat, res, busy_ok);
`ifdef SERIAL_SHIFT_RIGHT_FAST4_EN
            exp_lat = 32'(vecs[i].lat_fast);
`else
            exp_lat = 32'(vecs[i].lat_base);
`endif
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), exp_lat);
            check($sformatf("vec%0d_busy_through_done", i), {31'd0, busy_ok}, 32'd1);
            tick();
            check($sformatf("vec%0d_done_pulse_width", i), {30'd0, done, busy}, 32'd0);
            check($sformatf("vec%0d_result_held", i), result, vecs[i].exp);
        end

        // Operand changes and start pulses while busy are ignored; start is
        // then held high through DONE.
        data_in = 32'h8000_00F0;
        shamt   = 5'd4;
        arith   = 1'b0;
        start   = 1'b1;
        tick();
        data_in = 32'hFFFF_FFFF;
        shamt   = 5'd31;
        arith   = 1'b1;
        wait_done(lat, res, busy_ok);
        check("busy_ignore_result", res, 32'h0800_000F);
        check("busy_ignore_latency", 32'(lat), 32'(model_lat(5'd4)));
        tick();
        check("done_cycle_start_not_accepted", {31'd0, busy}, 32'd0);
        tick();
        check("accept_in_following_idle", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(lat, res, busy_ok);
        check("held_start_result", res, 32'hFFFF_FFFF);
        // Accept already happened one cycle before wait_done began counting.
        check("held_start_latency", 32'(lat), 32'(model_lat(5'd31)));
        tick();

        // Reference-operator sweep
        for (int n = 0; n < 1000; n++) begin
            d  = $urandom();
            s  = 5'($urandom_range(0, 31));
            a  = 1'($urandom_range(0, 1));
            sd = d;
            exp = a ? 32'(sd >>> s) : (d >> s);
            run_op(d, s, a, lat, res, busy_ok);
            check($sformatf("rand%0d_result d=%h s=%0d a=%0d", n, d, s, a), res, exp);
            check($sformatf("rand%0d_latency", n), 32'(lat), 32'(model_lat(s)));
            tick();
        end

        // Abort by asynchronous reset mid-SHIFT
        run_op(32'hFFFF_FFFF, 5'd0, 1'b0, lat, res, busy_ok);
        tick();
        check("pre_abort_result", result, 32'hFFFF_FFFF);
        data_in = 32'hA5A5_A5A5;
        shamt   = 5'd20;
        arith   = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        repeat (4) tick();
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   {31'd0, busy},   32'd0);
        check("abort_done",   {31'd0, done},   32'd0);
        check("abort_result", result,          32'd0);
        check("abort_state",  {30'd0, dbg_state}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
            tick();
        end
        check("no_done_after_abort", {31'd0, done_seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
